controle_multiciclo: RTL and testbench

- Multicycle instruction sequencer that sits directly upstream of the register file.
- Owns the 0..9 step counter `cont`, the program counter and the instruction register.
- Decodes register addresses and the write-enable that the register file consumes: read at step 5, R-type write at negedge of step 6, load write at posedge of step 9.
- Also drives the memory read/write strobes and resolves beq using the ALU zero flag.

---
 rtl/controle_multiciclo_pkg.sv | 34 +++
 rtl/controle_multiciclo_if.sv | 24 ++
 rtl/controle_multiciclo_decodificador.sv | 49 ++++
 rtl/controle_multiciclo.sv | 83 ++++++++
 tb/tb_controle_multiciclo.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/controle_multiciclo_pkg.sv
// Shared constants for the multicycle sequencer: opcodes, step numbers,
// instruction field positions and the branch offset helper.
package controle_multiciclo_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] STEP_LATCH_IR = 4'd4;
  localparam logic [3:0] STEP_RF_READ  = 4'd5;
  localparam logic [3:0] STEP_WB_R     = 4'd6;
  localparam logic [3:0] STEP_MEM      = 4'd7;
  localparam logic [3:0] STEP_BR       = 4'd8;
  localparam logic [3:0] STEP_WB_LW    = 4'd9;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Bus between the sequencer and the memory / register-file datapath.
interface controle_multiciclo_if;
  logic [31:0] instr;
  logic        zero;
  logic [3:0]  cont;
  logic [31:0] pc;
  logic [4:0]  rr1;
  logic [4:0]  rr2;
  logic [4:0]  wr;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic        illegal;

  modport master (
    input  instr, zero,
    output cont, pc, rr1, rr2, wr, regwrite, memread, memwrite, illegal
  );

  modport slave (
    output instr, zero,
    input  cont, pc, rr1, rr2, wr, regwrite, memread, memwrite, illegal
  );
endinterface

// File: rtl/controle_multiciclo_decodificador.sv
// Combinational decoder: instruction fields plus current step -> register
// addresses, write enable and memory strobes.
module decodificador
  import controle_multiciclo_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [3:0] cont,
  output logic [4:0] rr1,
  output logic [4:0] rr2,
  output logic [4:0] wr,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       illegal
);

  logic wb_step;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    rr1      = rs;
    rr2      = rt;
    wr       = rt;
    wb_step  = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        wr      = rd;
        wb_step = (cont == STEP_WB_R);
      end
      OP_ADDI: wb_step = (cont == STEP_WB_R);
      OP_LW: begin
        memread = (cont == STEP_MEM) || (cont == STEP_BR);
        wb_step = (cont == STEP_WB_LW);
      end
      OP_SW:   memwrite = (cont == STEP_MEM);
      OP_BEQ:  ;
      default: illegal = (cont >= STEP_RF_READ);
    endcase
    // $zero is hardwired, so a write addressed to it is suppressed.
    regwrite = wb_step && (wr != 5'd0);
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle instruction sequencer: step counter, pc and instruction register.
// Optional HALT_ON_ILLEGAL_EN freezes the sequencer on an unsupported opcode.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          LAST_STEP = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  controle_multiciclo_if.master   bus
);

  localparam logic [3:0] LAST = LAST_STEP[3:0];

  logic [3:0]  cont;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        taken;
  logic        hold;
  logic [5:0]  op;

  assign op = ir[OP_MSB:OP_LSB];

  decodificador u_dec (
    .op       (op),
    .rs       (ir[RS_MSB:RS_LSB]),
    .rt       (ir[RT_MSB:RT_LSB]),
    .rd       (ir[RD_MSB:RD_LSB]),
    .cont     (cont),
    .rr1      (bus.rr1),
    .rr2      (bus.rr2),
    .wr       (bus.wr),
    .regwrite (bus.regwrite),
    .memread  (bus.memread),
    .memwrite (bus.memwrite),
    .illegal  (bus.illegal)
  );

`ifdef HALT_ON_ILLEGAL_EN
  logic halted;

  // Once halted, cont stays at the last step and only rst releases it.
  assign hold = halted || ((cont == LAST) && bus.illegal);

  always_ff @(posedge clk) begin
    if (rst)
      halted <= 1'b0;
    else if ((cont == LAST) && bus.illegal)
      halted <= 1'b1;
  end
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      cont  <= 4'd0;
      pc    <= RESET_PC;
      ir    <= 32'd0;
      taken <= 1'b0;
    end else if (!hold) begin
      cont <= (cont == LAST) ? 4'd0 : cont + 4'd1;
      if (cont == STEP_LATCH_IR)
        ir <= bus.instr;
      if (cont == STEP_BR)
        taken <= bus.zero;
      else if (cont == 4'd0)
        taken <= 1'b0;
      if (cont == LAST) begin
        if ((op == OP_BEQ) && taken)
          pc <= pc + 32'd4 + branch_offset(ir[IMM_MSB:IMM_LSB]);
        else
          pc <= pc + 32'd4;
      end
    end
  end

  assign bus.cont = cont;
  assign bus.pc   = pc;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: a cycle model pushes expected
// outputs after each clock edge, a negedge monitor pops and compares them.
module tb_controle_multiciclo;

`ifdef HALT_ON_ILLEGAL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  typedef struct {
    logic [3:0]  cont;
    logic [31:0] pc;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic        has_wr;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  controle_multiciclo_if bus ();

  controle_multiciclo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [3:0]  m_cont = 4'd0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_ir = 32'd0;
  logic        m_taken = 1'b0;
  logic        m_halted = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs for a given instruction register, step and pc.
  function automatic exp_t expect_of(input logic [31:0] ir, input logic [3:0] c,
                                     input logic [31:0] p);
    exp_t e;
    e.cont = c; e.pc = p;
    e.rr1 = ir[25:21]; e.rr2 = ir[20:16];
    e.wr = 5'd0; e.has_wr = 1'b0;
    e.regwrite = 1'b0; e.memread = 1'b0; e.memwrite = 1'b0; e.illegal = 1'b0;
    case (ir[31:26])
      6'h00: begin e.wr = ir[15:11]; e.has_wr = 1'b1; e.regwrite = (c == 4'd6); end
      6'h08: begin e.wr = ir[20:16]; e.has_wr = 1'b1; e.regwrite = (c == 4'd6); end
      6'h23: begin
        e.wr = ir[20:16]; e.has_wr = 1'b1;
        e.memread = (c == 4'd7 || c == 4'd8);
        e.regwrite = (c == 4'd9);
      end
      6'h2B: e.memwrite = (c == 4'd7);
      6'h04: ;
      default: e.illegal = (c >= 4'd5 && c <= 4'd9);
    endcase
    if (e.has_wr && e.wr == 5'd0) e.regwrite = 1'b0;
    return e;
  endfunction

  task automatic model_clock();
    exp_t cur;
    cur = expect_of(m_ir, m_cont, m_pc);
    if (rst) begin
      m_cont = 4'd0; m_pc = 32'd0; m_ir = 32'd0; m_taken = 1'b0; m_halted = 1'b0;
    end else if (!m_halted) begin
      if (HALT && m_cont == 4'd9 && cur.illegal) begin
        m_halted = 1'b1;
      end else begin
        if (m_cont == 4'd4) m_ir = bus.instr;
        if (m_cont == 4'd0) m_taken = 1'b0;
        if (m_cont == 4'd8) m_taken = bus.zero;
        if (m_cont == 4'd9) begin
          if (m_ir[31:26] == 6'h04 && m_taken)
            m_pc = m_pc + 32'd4 + {{14{m_ir[15]}}, m_ir[15:0], 2'b00};
          else
            m_pc = m_pc + 32'd4;
        end
        m_cont = (m_cont == 4'd9) ? 4'd0 : m_cont + 4'd1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    sb.push_back(expect_of(m_ir, m_cont, m_pc));
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic z);
    bus.instr = ins;
    bus.zero  = z;
    repeat (10) step();
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("cont",     32'(bus.cont),     32'(e.cont));
      check("pc",       bus.pc,            e.pc);
      check("rr1",      32'(bus.rr1),      32'(e.rr1));
      check("rr2",      32'(bus.rr2),      32'(e.rr2));
      if (e.has_wr) check("wr", 32'(bus.wr), 32'(e.wr));
      check("regwrite", 32'(bus.regwrite), 32'(e.regwrite));
      check("memread",  32'(bus.memread),  32'(e.memread));
      check("memwrite", 32'(bus.memwrite), 32'(e.memwrite));
      check("illegal",  32'(bus.illegal),  32'(e.illegal));
    end
  end

  initial begin
    bus.instr = 32'd0;
    bus.zero  = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    run_instr(32'h1000_FFFE, 1'b1);  // beq taken backwards: pc 0 -> FFFF_FFFC
    run_instr(32'h0022_1820, 1'b0);  // add $3,$1,$2 at FFFF_FFFC: pc wraps to 0
    run_instr(32'h8C85_0008, 1'b0);  // lw $5,8($4)
    run_instr(32'h2020_0005, 1'b0);  // addi $0,$1,5: no write
    run_instr(32'hAC22_0004, 1'b1);  // sw $2,4($1)
    run_instr(32'h0022_1820, 1'b0);  // add -> pc 0x10
    run_instr(32'h1021_0003, 1'b1);  // beq taken: 0x10 -> 0x20
    run_instr(32'h1021_0003, 1'b0);  // beq not taken: 0x20 -> 0x24
    run_instr(32'h1021_FFFF, 1'b1);  // beq -1: stays at 0x24
    run_instr(32'hFC00_0000, 1'b1);  // unsupported opcode
    bus.instr = 32'h0022_1820;
    bus.zero  = 1'b0;
    repeat (6) step();               // halted build: still frozen at step 9

    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.instr = 32'h0022_1820;
    repeat (6) step();               // add up to step 6 (regwrite high)
    rst = 1'b1;
    step();                          // abort: cont=0, regwrite=0
    rst = 1'b0;
    run_instr(32'h0022_1820, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
